// File: rtl/warp_operand_scoreboard.sv
// warp_operand_scoreboard
//   Per-warp register scoreboard feeding the issue/dispatch arbiter. Each warp
//   holds one head instruction (loaded from decode). Destination writes that
//   are in flight are tracked per register. scoreboard[w] is 1 when warp w's
//   head operands are ready to issue.
//
//   Optional feature: define SB_WB_BYPASS_EN to fold a writeback in the
//   current cycle into the scoreboard computation. This gives 0-cycle wakeup
//   through a combinational wb_* -> scoreboard path. When it is undefined,
//   scoreboard depends on registered state only.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   dec_valid/warp/src0/src1/dst/has_dst
//                               load the head instruction for dec_warp
//   iss_valid, iss_warp         arbiter dispatched iss_warp
//   wb_valid, wb_warp, wb_dst   writeback completion of wb_dst
//   scoreboard [W]              per-warp operands-ready
//   head_free  [W]              per-warp head slot empty
//   sb_err                      sticky protocol-error flag
module warp_operand_scoreboard #(
    parameter int W    = 32,
    parameter int NR   = 64,
    parameter int MAXP = 4,
    parameter int WID  = $clog2(W),
    parameter int RID  = $clog2(NR)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           dec_valid,
    input  logic [WID-1:0] dec_warp,
    input  logic [RID-1:0] dec_src0,
    input  logic [RID-1:0] dec_src1,
    input  logic [RID-1:0] dec_dst,
    input  logic           dec_has_dst,
    input  logic           iss_valid,
    input  logic [WID-1:0] iss_warp,
    input  logic           wb_valid,
    input  logic [WID-1:0] wb_warp,
    input  logic [RID-1:0] wb_dst,
    output logic [W-1:0]   scoreboard,
    output logic [W-1:0]   head_free,
    output logic           sb_err
);

    localparam int PW = $clog2(MAXP + 1);
    localparam logic [PW-1:0] MAXP_C = PW'(MAXP);

    logic [W-1:0]   head_valid;
    logic [RID-1:0] head_src0    [W];
    logic [RID-1:0] head_src1    [W];
    logic [RID-1:0] head_dst     [W];
    logic           head_has_dst [W];
    logic [NR-1:0]  pending      [W];
    logic [PW-1:0]  pcnt         [W];

    logic iss_ok, wb_ok, dec_ok, iss_set;

    // A writeback is legal only for a nonzero register that is actually pending.
    assign wb_ok  = wb_valid && (wb_dst != '0) && pending[wb_warp][wb_dst];
    assign iss_ok = iss_valid && scoreboard[iss_warp];
    // Decode may replace a head that is being issued in the same cycle.
    assign dec_ok = dec_valid && (!head_valid[dec_warp] ||
                                  (iss_ok && (iss_warp == dec_warp)));
    // Register 0 is never tracked as pending.
    assign iss_set = iss_ok && head_has_dst[iss_warp] && (head_dst[iss_warp] != '0);

    assign head_free = ~head_valid;

    // NOTE: p and cnt receive a value at the start of every iteration before
    // they are read, so no latch is inferred.
    always_comb begin
        logic [NR-1:0] p;
        logic [PW-1:0] cnt;
        scoreboard = '0;
        for (int w = 0; w < W; w++) begin
            p   = pending[w];
            cnt = pcnt[w];
`ifdef SB_WB_BYPASS_EN
            if (wb_ok && (wb_warp == WID'(w))) begin
                p[wb_dst] = 1'b0;
                cnt       = cnt - 1'b1;
            end
`endif
            scoreboard[w] = head_valid[w]
                          & ~p[head_src0[w]]
                          & ~p[head_src1[w]]
                          & ~(head_has_dst[w] & p[head_dst[w]])
                          & ~(head_has_dst[w] & (cnt == MAXP_C));
        end
    end

    // NOTE: head operand fields are not reset. They are only read while
    // head_valid is set, and head_valid is cleared on reset. The pending
    // array is reset, because scoreboard readiness depends on it directly.
    always_ff @(posedge clk) begin
        if (dec_ok) begin
            head_src0[dec_warp]    <= dec_src0;
            head_src1[dec_warp]    <= dec_src1;
            head_dst[dec_warp]     <= dec_dst;
            head_has_dst[dec_warp] <= dec_has_dst;
        end
    end

    // NOTE: all state here uses non-blocking assignments. When two updates
    // hit the same bit, the later statement wins. The order below makes
    // decode-after-issue and set-after-clear take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid <= '0;
            sb_err     <= 1'b0;
            for (int w = 0; w < W; w++) begin
                pending[w] <= '0;
                pcnt[w]    <= '0;
            end
        end else begin
            if (iss_ok) head_valid[iss_warp] <= 1'b0;
            if (dec_ok) head_valid[dec_warp] <= 1'b1;

            if (wb_ok)   pending[wb_warp][wb_dst] <= 1'b0;
            if (iss_set) pending[iss_warp][head_dst[iss_warp]] <= 1'b1;

            // When issue and writeback hit the same warp, the count is unchanged.
            if (iss_set && !(wb_ok && (wb_warp == iss_warp)))
                pcnt[iss_warp] <= pcnt[iss_warp] + 1'b1;
            if (wb_ok && !(iss_set && (wb_warp == iss_warp)))
                pcnt[wb_warp] <= pcnt[wb_warp] - 1'b1;

            if ((dec_valid && !dec_ok) || (iss_valid && !iss_ok) || (wb_valid && !wb_ok))
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_warp_operand_scoreboard.sv
// Self-checking bench for warp_operand_scoreboard. It runs directed scenarios
// followed by randomized traffic. All results are compared against a
// behavioural model that applies the scoreboard rules to plain arrays.
module tb_warp_operand_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_warp = '0;
    logic [5:0] dec_src0 = '0, dec_src1 = '0, dec_dst = '0;
    logic       dec_has_dst = 1'b0;
    logic       iss_valid = 1'b0;
    logic [4:0] iss_warp = '0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_warp = '0;
    logic [5:0] wb_dst = '0;
    logic [31:0] scoreboard, head_free;
    logic        sb_err;

    int n_pass = 0;
    int n_total = 0;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    warp_operand_scoreboard dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_warp(dec_warp), .dec_src0(dec_src0),
        .dec_src1(dec_src1), .dec_dst(dec_dst), .dec_has_dst(dec_has_dst),
        .iss_valid(iss_valid), .iss_warp(iss_warp),
        .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_dst(wb_dst),
        .scoreboard(scoreboard), .head_free(head_free), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit m_hv [32];
    int m_s0 [32], m_s1 [32], m_d [32];
    bit m_hd [32];
    bit m_pend [32][64];
    int m_cnt [32];
    bit m_err;

    task automatic m_reset();
        for (int w = 0; w < 32; w++) begin
            m_hv[w] = 0; m_cnt[w] = 0;
            for (int r = 0; r < 64; r++) m_pend[w][r] = 0;
        end
        m_err = 0;
    endtask

    function automatic bit wb_legal();
        return wb_valid && wb_dst != 0 && m_pend[wb_warp][wb_dst];
    endfunction

    // A register counts as pending unless a bypassed writeback is clearing it now.
    function automatic bit busy(int w, int r);
        if (BYPASS && wb_legal() && int'(wb_warp) == w && int'(wb_dst) == r) return 0;
        return m_pend[w][r];
    endfunction

    function automatic bit ready(int w);
        int outstanding = m_cnt[w];
        if (BYPASS && wb_legal() && int'(wb_warp) == w) outstanding--;
        if (!m_hv[w]) return 0;
        if (busy(w, m_s0[w]) || busy(w, m_s1[w])) return 0;
        if (m_hd[w] && (busy(w, m_d[w]) || outstanding >= 4)) return 0;
        return 1;
    endfunction

    task automatic m_step();
        bit iok, wok, dok;
        int iw = iss_warp, ww = wb_warp, dw = dec_warp;
        iok = iss_valid && ready(iw);
        wok = wb_legal();
        dok = dec_valid && (!m_hv[dw] || (iok && iw == dw));
        if ((iss_valid && !iok) || (wb_valid && !wok) || (dec_valid && !dok)) m_err = 1;
        if (wok) begin
            m_pend[ww][wb_dst] = 0;
            m_cnt[ww]--;
        end
        if (iok) begin
            if (m_hd[iw] && m_d[iw] != 0) begin
                if (!m_pend[iw][m_d[iw]] || !wok || ww != iw) m_cnt[iw]++;
                else if (int'(wb_dst) != m_d[iw]) m_cnt[iw]++;
                else m_cnt[iw]++;
                m_pend[iw][m_d[iw]] = 1;
            end
            m_hv[iw] = 0;
        end
        if (dok) begin
            m_hv[dw] = 1; m_s0[dw] = dec_src0; m_s1[dw] = dec_src1;
            m_d[dw] = dec_dst; m_hd[dw] = dec_has_dst;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic check_all(string tag);
        logic [31:0] e_sb, e_hf;
        for (int w = 0; w < 32; w++) begin
            e_sb[w] = ready(w);
            e_hf[w] = !m_hv[w];
        end
        check({tag, "_sb"}, scoreboard, e_sb);
        check({tag, "_hf"}, head_free, e_hf);
        check({tag, "_err"}, {31'd0, sb_err}, {31'd0, m_err});
    endtask

    task automatic clear_in();
        dec_valid = 0; iss_valid = 0; wb_valid = 0;
    endtask

    // Inputs are set by the caller shortly after a negedge. This task checks
    // them, steps the model on the edge, then clears the inputs.
    task automatic cyc(string tag);
        #1 check_all(tag);
        @(posedge clk);
        m_step();
        @(negedge clk);
        clear_in();
        #1;
    endtask

    task automatic set_dec(int w, int s0, int s1, int d, bit hd);
        dec_valid = 1; dec_warp = 5'(w); dec_src0 = 6'(s0);
        dec_src1 = 6'(s1); dec_dst = 6'(d); dec_has_dst = hd;
    endtask
    task automatic set_iss(int w);
        iss_valid = 1; iss_warp = 5'(w);
    endtask
    task automatic set_wb(int w, int r);
        wb_valid = 1; wb_warp = 5'(w); wb_dst = 6'(r);
    endtask

    initial begin
        m_reset();
        #2 check("rst_sb", scoreboard, 32'h0);
        check("rst_hf", head_free, 32'hFFFF_FFFF);
        check("rst_err", {31'd0, sb_err}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;

        // Warp 3: ready, issue, then dependent head waits on writeback.
        set_dec(3, 5, 6, 7, 1); cyc("t2a");
        check("t2_sb3", {31'd0, scoreboard[3]}, 32'd1);
        set_iss(3); cyc("t2b");
        check("t2_hf3", {31'd0, head_free[3]}, 32'd1);
        set_dec(3, 7, 6, 8, 1); cyc("t2c");
        check("t2_sb3_wait", {31'd0, scoreboard[3]}, 32'd0);
        cyc("t2d");
        set_wb(3, 7);
        #1 check("t2_sb3_bypass", {31'd0, scoreboard[3]}, {31'd0, BYPASS});
        cyc("t2e");
        check("t2_sb3_wake", {31'd0, scoreboard[3]}, 32'd1);

        // Warp 0: four outstanding writes saturate the counter.
        for (int i = 1; i <= 4; i++) begin
            set_dec(0, 0, 0, i, 1); cyc("t3dec");
            set_iss(0); cyc("t3iss");
        end
        set_dec(0, 0, 0, 9, 1); cyc("t3full");
        check("t3_sb0_sat", {31'd0, scoreboard[0]}, 32'd0);
        set_wb(0, 2); cyc("t3wb");
        check("t3_sb0_free", {31'd0, scoreboard[0]}, 32'd1);

        // Warp 5: issue r10 together with writeback of r11.
        set_dec(5, 1, 1, 11, 1); cyc("t4a");
        set_iss(5); cyc("t4b");
        set_dec(5, 1, 1, 10, 1); cyc("t4c");
        set_iss(5); set_wb(5, 11); cyc("t4d");
        check("t4_p10", {31'd0, dut.pending[5][10]}, 32'd1);
        check("t4_p11", {31'd0, dut.pending[5][11]}, 32'd0);
        check("t4_pcnt", {29'd0, dut.pcnt[5]}, 32'd1);
        check("t4_err_clean", {31'd0, sb_err}, 32'd0);

        // Warp 2: protocol errors leave state untouched.
        set_dec(2, 0, 0, 20, 1); cyc("t5a");
        set_iss(2); cyc("t5b");
        set_dec(2, 20, 0, 0, 0); cyc("t5c");
        set_dec(2, 1, 1, 1, 0); cyc("t5d");
        check("t5_err", {31'd0, sb_err}, 32'd1);
        check("t5_sb2", {31'd0, scoreboard[2]}, 32'd0);
        set_wb(2, 21); cyc("t5e");
        set_iss(2); cyc("t5f");
        check("t5_hf2", {31'd0, head_free[2]}, 32'd0);
        check("t5_p20", {31'd0, dut.pending[2][20]}, 32'd1);

        // Warp 8: decode and issue in the same cycle.
        set_dec(8, 0, 0, 12, 1); cyc("t6a");
        set_dec(8, 12, 0, 13, 1); set_iss(8); cyc("t6b");
        check("t6_hf8", {31'd0, head_free[8]}, 32'd0);
        check("t6_sb8", {31'd0, scoreboard[8]}, 32'd0);

        // Randomized traffic over a few warps and registers to force collisions.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(1, 0) == 1)
                set_dec($urandom_range(3, 0), $urandom_range(7, 0),
                        $urandom_range(7, 0), $urandom_range(7, 0), 1'($urandom));
            if ($urandom_range(1, 0) == 1) set_iss($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) set_wb($urandom_range(3, 0), $urandom_range(7, 0));
            cyc("rnd");
        end

        // Asynchronous reset in the middle of traffic.
        set_dec(1, 2, 3, 4, 1); set_iss(0); set_wb(0, 1);
        #2 rst_n = 0;
        #1 check("mrst_sb", scoreboard, 32'h0);
        check("mrst_hf", head_free, 32'hFFFF_FFFF);
        check("mrst_err", {31'd0, sb_err}, 32'd0);
        m_reset();
        @(negedge clk);
        clear_in();
        rst_n = 1;
        #1;
        for (int n = 0; n < 100; n++) begin
            if ($urandom_range(1, 0) == 1)
                set_dec($urandom_range(3, 0), $urandom_range(7, 0),
                        $urandom_range(7, 0), $urandom_range(7, 0), 1'($urandom));
            if ($urandom_range(1, 0) == 1) set_iss($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) set_wb($urandom_range(3, 0), $urandom_range(7, 0));
            cyc("rnd2");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
